nonce_sweeper: RTL and testbench

- Upstream job controller for accel: accepts a mining job (80-byte header template, target, nonce range) and drives accel's hash_start/blk_hdr once per nonce.
- Consumes hash/hash_done and compares each hash against the target.
- Stops at the first winning nonce or at range exhaustion, then returns one result through a valid/ready handshake.

---
 rtl/nonce_sweeper.sv | 174 +++++++++++++++++
 tb/tb_nonce_sweeper.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweeper.sv
// Nonce sweeper: walks a nonce range over an 80-byte header template, drives the
// hash accelerator once per nonce and returns the first winner or the last nonce tried.
module nonce_sweeper #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [639:0]       job_hdr,
  input  logic [255:0]       job_target,
  input  logic [31:0]        job_nonce_first,
  input  logic [31:0]        job_nonce_last,
  input  logic               abort,
  output logic               hash_start,
  output logic [639:0]       blk_hdr,
  input  logic               hash_done,
  input  logic [255:0]       hash,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic               res_timeout,
  output logic [31:0]        res_nonce,
  output logic [255:0]       res_hash,
  output logic               busy,
  output logic [CNT_W-1:0]   hash_count
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_RESULT, S_DRAIN
  } state_t;

  state_t              r_state;
  logic [607:0]        r_hdr_hi;
  logic [255:0]        r_target;
  logic [255:0]        r_hash;
  logic [31:0]         r_nonce;
  logic [31:0]         r_last;
  logic [WCNT_W-1:0]   r_wait_cnt;

  logic [255:0]        w_hash_le;
  logic                w_win;
  logic                w_timeout;
  logic [31:0]         w_nonce_next;
  logic                w_unused;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  always_comb begin
    w_hash_le = '0;
    for (int i = 0; i < 32; i++) w_hash_le[8*i +: 8] = r_hash[8*(31-i) +: 8];
  end

  assign w_win        = (w_hash_le <= r_target);
  assign w_nonce_next = r_nonce + 32'd1;
  // Counter is cleared in ISSUE, so matching TIMEOUT-2 puts res_valid exactly
  // TIMEOUT_CYCLES cycles after the hash_start cycle.
  assign w_timeout    = (r_wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 2));
  // Combinational so an abort in the ISSUE cycle suppresses the pulse.
  assign hash_start   = (r_state == S_ISSUE) && !abort;
  assign w_unused     = ^job_hdr[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hdr_hi    <= '0;
      r_target    <= '0;
      r_hash      <= '0;
      r_nonce     <= '0;
      r_last      <= '0;
      r_wait_cnt  <= '0;
      job_ready   <= 1'b1;
      blk_hdr     <= '0;
      res_valid   <= 1'b0;
      res_found   <= 1'b0;
      res_timeout <= 1'b0;
      res_nonce   <= '0;
      res_hash    <= '0;
      busy        <= 1'b0;
      hash_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_hdr_hi   <= job_hdr[639:32];
            r_target   <= job_target;
            r_nonce    <= job_nonce_first;
            r_last     <= job_nonce_last;
            blk_hdr    <= {job_hdr[639:32], bswap32(job_nonce_first)};
            hash_count <= '0;
            job_ready  <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          if (abort) begin
            job_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          if (abort) begin
            // A completion or timeout in the same cycle already leaves accel idle.
            if (hash_done || w_timeout) begin
              job_ready <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (hash_done) begin
            r_hash <= hash;
            if (hash_count != {CNT_W{1'b1}}) hash_count <= hash_count + CNT_W'(1);
            r_state <= S_CHECK;
          end else if (w_timeout) begin
            res_valid   <= 1'b1;
            res_found   <= 1'b0;
            res_timeout <= 1'b1;
            res_nonce   <= r_nonce;
            res_hash    <= '0;
            r_state     <= S_RESULT;
          end
        end
        S_CHECK: begin
          if (abort) begin
            job_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_win || (r_nonce == r_last)) begin
            res_valid   <= 1'b1;
            res_found   <= w_win;
            res_timeout <= 1'b0;
            res_nonce   <= r_nonce;
            res_hash    <= r_hash;
            r_state     <= S_RESULT;
          end else begin
            r_nonce <= w_nonce_next;
            blk_hdr <= {r_hdr_hi, bswap32(w_nonce_next)};
            r_state <= S_ISSUE;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          if (hash_done || w_timeout) begin
            job_ready <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench for nonce_sweeper with a fixed-latency accelerator model.
module tb_nonce_sweeper;
  localparam int TO = 1024;
  localparam logic [639:0] GEN_HDR = 640'h01000000_00000000000000000000000000000000_00000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
  localparam logic [255:0] GEN_HASH = 256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000;
  localparam logic [255:0] GEN_LE   = 256'h00000000_0019d668_9c085ae1_65831e93_4ff763ae_46a2a6c1_72b3f1b6_0a8ce26f;
  localparam logic [255:0] TGT2     = 256'hFFFF << 208;
  localparam logic [255:0] ONES     = {256{1'b1}};

  logic         clk, rst;
  logic         job_valid, job_ready, abort, hash_start, hash_done;
  logic [639:0] job_hdr, blk_hdr;
  logic [255:0] job_target, hash, res_hash;
  logic [31:0]  job_nonce_first, job_nonce_last, res_nonce;
  logic         res_valid, res_ready, res_found, res_timeout, busy;
  logic [31:0]  hash_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  nonce_sweeper #(.TIMEOUT_CYCLES(TO), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_hdr(job_hdr),
    .job_target(job_target), .job_nonce_first(job_nonce_first),
    .job_nonce_last(job_nonce_last), .abort(abort),
    .hash_start(hash_start), .blk_hdr(blk_hdr), .hash_done(hash_done), .hash(hash),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_timeout(res_timeout), .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .hash_count(hash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Accelerator model: hash_done goes high lat cycles after the hash_start cycle.
  int          lat = 3;
  bit          never = 1'b0;
  logic        acc_active;
  int          acc_cnt;
  logic [31:0] acc_nf;
  logic [31:0] start_log[$];
  int          start_cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_active <= 1'b0;
      hash_done  <= 1'b0;
      hash       <= '0;
    end else begin
      hash_done <= 1'b0;
      if (hash_start) begin
        acc_active <= 1'b1;
        acc_cnt    <= lat - 1;
        acc_nf     <= blk_hdr[31:0];
        start_cyc  <= cyc;
        start_log.push_back(blk_hdr[31:0]);
      end else if (acc_active && !never) begin
        if (acc_cnt <= 1) begin
          hash_done  <= 1'b1;
          hash       <= (acc_nf == 32'h1dac2b7c) ? GEN_HASH : ONES;
          acc_active <= 1'b0;
        end else begin
          acc_cnt <= acc_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[8*(31-i) +: 8];
    return r;
  endfunction

  task automatic start_job(input logic [639:0] h, input logic [255:0] t,
                           input logic [31:0] f, input logic [31:0] l);
    int k;
    k = 0;
    while (!job_ready && k < 100) begin tick(); k++; end
    chk("job_ready_before_start", job_ready, 1);
    job_hdr = h; job_target = t; job_nonce_first = f; job_nonce_last = l;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int bound, output int got_cyc);
    int k;
    k = 0;
    while (!res_valid && k < bound) begin tick(); k++; end
    got_cyc = cyc;
    chk("res_valid_arrived", res_valid, 1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("job_ready_return", job_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int rc, n0, jr_cyc;
    bit seen_res;
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    job_hdr = '0; job_target = '0; job_nonce_first = '0; job_nonce_last = '0;
    repeat (2) tick();
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_hash_start", hash_start, 0);
    chk("rst_blk_hdr", blk_hdr[255:0], 0);
    chk("rst_hash_count", hash_count, 0);
    rst = 1'b0;
    tick();

    // Genesis, single nonce, target all-ones; then hold the result 20 cycles.
    start_log.delete();
    start_job(GEN_HDR, ONES, 32'h7c2bac1d, 32'h7c2bac1d);
    chk("g1_busy", busy, 1);
    wait_res(200, rc);
    chk("g1_found", res_found, 1);
    chk("g1_timeout", res_timeout, 0);
    chk("g1_nonce", res_nonce, 32'h7c2bac1d);
    chk("g1_hash", res_hash, GEN_HASH);
    chk("g1_hash_le", bswap256(res_hash), GEN_LE);
    chk("g1_count", hash_count, 1);
    chk("g1_starts", start_log.size(), 1);
    for (int i = 0; i < 20; i++) begin
      chk("hold_res", {res_valid, res_found, res_timeout, res_nonce, res_hash[31:0], job_ready},
          {1'b1, 1'b1, 1'b0, 32'h7c2bac1d, GEN_HASH[31:0], 1'b0});
      tick();
    end
    consume();
    chk("g1_count_held", hash_count, 1);

    // Genesis over a range with the real difficulty target.
    start_log.delete();
    start_job(GEN_HDR, TGT2, 32'h7c2bac1a, 32'h7c2bac20);
    wait_res(400, rc);
    chk("g2_found", res_found, 1);
    chk("g2_nonce", res_nonce, 32'h7c2bac1d);
    chk("g2_count", hash_count, 4);
    chk("g2_starts", start_log.size(), 4);
    chk("g2_first_blk", start_log[0], 32'h1aac2b7c);
    chk("g2_last_blk", start_log[start_log.size()-1], 32'h1dac2b7c);
    chk("g2_hdr_upper", blk_hdr[639:32], GEN_HDR[639:32]);
    consume();

    // Wrap through 0xFFFFFFFF with every hash losing.
    lat = 5;
    start_log.delete();
    start_job(GEN_HDR, '0, 32'hfffffffe, 32'h00000001);
    wait_res(400, rc);
    chk("wrap_found", res_found, 0);
    chk("wrap_nonce", res_nonce, 32'h00000001);
    chk("wrap_count", hash_count, 4);
    chk("wrap_hash", res_hash, ONES);
    chk("wrap_starts", start_log.size(), 4);
    chk("wrap_seq0", start_log[0], 32'hfeffffff);
    chk("wrap_seq1", start_log[1], 32'hffffffff);
    chk("wrap_seq2", start_log[2], 32'h00000000);
    chk("wrap_seq3", start_log[3], 32'h01000000);
    consume();

    // Accelerator never answers.
    never = 1'b1;
    start_job(GEN_HDR, ONES, 32'h00000042, 32'h00000050);
    wait_res(TO + 50, rc);
    chk("to_latency", rc - start_cyc, TO);
    chk("to_timeout", res_timeout, 1);
    chk("to_found", res_found, 0);
    chk("to_nonce", res_nonce, 32'h00000042);
    chk("to_count", hash_count, 0);
    consume();
    never = 1'b0;

    // Abort in WAIT: drain until the accelerator answers, no result.
    lat = 10;
    start_job(GEN_HDR, '0, 32'h5, 32'h5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seen_res = 1'b0;
    jr_cyc = -1;
    for (int i = 0; i < 40 && jr_cyc < 0; i++) begin
      if (res_valid) seen_res = 1'b1;
      if (job_ready) jr_cyc = cyc;
      else tick();
    end
    chk("abort_wait_no_res", seen_res, 0);
    chk("abort_wait_ready_cycle", jr_cyc - start_cyc, 11);
    n0 = start_log.size();
    lat = 3;
    start_job(GEN_HDR, ONES, 32'h7c2bac1d, 32'h7c2bac1d);
    wait_res(200, rc);
    chk("after_abort_found", res_found, 1);
    chk("after_abort_count", hash_count, 1);
    chk("after_abort_starts", start_log.size() - n0, 1);
    consume();

    // Abort coinciding with ISSUE: no hash_start, straight back to IDLE.
    n0 = start_log.size();
    start_job(GEN_HDR, ONES, 32'h9, 32'h9);
    abort = 1'b1;
    #1;
    chk("abort_issue_no_start", hash_start, 0);
    tick();
    abort = 1'b0;
    chk("abort_issue_ready", job_ready, 1);
    chk("abort_issue_busy", busy, 0);
    chk("abort_issue_starts", start_log.size() - n0, 0);
    tick();
    chk("abort_issue_no_res", res_valid, 0);

    // Reset in the middle of WAIT.
    lat = 10;
    start_job(GEN_HDR, ONES, 32'h77, 32'h80);
    tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_job_ready", job_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hash_start", hash_start, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_blk_hdr", {blk_hdr[639:384] != 0, blk_hdr[255:0]}, 0);
    chk("mid_rst_res_nonce", res_nonce, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {job_ready, busy}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
